// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one main-memory port between the I-cache and D-cache.
// One cache is granted at a time. The granted cache's request goes straight
// through to memory, and its response returns in the same cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no grant; pick a pending cache (round robin or D priority)
// SERVE_I | I-cache owns the memory port until pmem_resp or it drops
// SERVE_D | D-cache owns the memory port until pmem_resp or it drops
// RELEASE | one dead cycle so the served cache can lower its request
module cache_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 256,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    logic   last_grant_d;
    logic   i_pend;
    logic   d_pend;
    logic   d_wins;

    assign i_pend = i_pmem_read | i_pmem_write;
    assign d_pend = d_pmem_read | d_pmem_write;

    // D wins when alone, under fixed priority, or when I was served last.
    assign d_wins = d_pend && (!i_pend || (ROUND_ROBIN == 0) || !last_grant_d);

    // Grant state machine; last_grant_d records who was granted most recently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wins) begin
                        state        <= SERVE_D;
                        last_grant_d <= 1'b1;
                    end else if (i_pend) begin
                        state        <= SERVE_I;
                        last_grant_d <= 1'b0;
                    end
                end
                SERVE_I: begin
                    // A response ends the transfer even if the cache drops the same cycle.
                    if (pmem_resp) begin
                        state <= RELEASE;
                    end else if (!i_pend) begin
                        state <= IDLE;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state <= RELEASE;
                    end else if (!d_pend) begin
                        state <= IDLE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Route the granted cache to memory; everything idles at 0 otherwise, which
    // also forces all outputs low as soon as reset pulls the state to IDLE.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        case (state)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_write   = i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_resp  = pmem_resp;
                i_pmem_rdata = pmem_rdata;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                d_pmem_rdata = pmem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter. Two instances are used:
// dut (round robin) and dut_fp (fixed D-cache priority).
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          i_pmem_read, i_pmem_write, i_pmem_resp;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_wdata, i_pmem_rdata;
    logic          d_pmem_read, d_pmem_write, d_pmem_resp;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata, d_pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    logic          f_i_pmem_read, f_i_pmem_write, f_i_pmem_resp;
    logic [AW-1:0] f_i_pmem_address;
    logic [LW-1:0] f_i_pmem_wdata, f_i_pmem_rdata;
    logic          f_d_pmem_read, f_d_pmem_write, f_d_pmem_resp;
    logic [AW-1:0] f_d_pmem_address;
    logic [LW-1:0] f_d_pmem_wdata, f_d_pmem_rdata;
    logic          f_pmem_read, f_pmem_write, f_pmem_resp;
    logic [AW-1:0] f_pmem_address;
    logic [LW-1:0] f_pmem_wdata, f_pmem_rdata;

    int errors = 0;
    int checks = 0;
    int illegal_cnt = 0;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(f_i_pmem_read), .i_pmem_write(f_i_pmem_write),
        .i_pmem_address(f_i_pmem_address), .i_pmem_wdata(f_i_pmem_wdata),
        .i_pmem_resp(f_i_pmem_resp), .i_pmem_rdata(f_i_pmem_rdata),
        .d_pmem_read(f_d_pmem_read), .d_pmem_write(f_d_pmem_write),
        .d_pmem_address(f_d_pmem_address), .d_pmem_wdata(f_d_pmem_wdata),
        .d_pmem_resp(f_d_pmem_resp), .d_pmem_rdata(f_d_pmem_rdata),
        .pmem_read(f_pmem_read), .pmem_write(f_pmem_write),
        .pmem_address(f_pmem_address), .pmem_wdata(f_pmem_wdata),
        .pmem_resp(f_pmem_resp), .pmem_rdata(f_pmem_rdata)
    );

    always #5 clk = ~clk;

    // Flag a cache raising read and write together (illegal request).
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(i_pmem_read && i_pmem_write) && !(d_pmem_read && d_pmem_write))
                else illegal_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
        return {8{a ^ 32'hC3C3_1234}};
    endfunction

    localparam logic [LW-1:0] A5 = {32{8'hA5}};
    localparam logic [LW-1:0] WD = {8{32'hDEAD_0800}};

    logic          i_req, d_req, i_w, d_w, i_drop, d_drop, mem_busy;
    int            mem_lat, i_wait, d_wait, max_wait, n_req, n_done;

    initial begin
        rst_n = 1'b0;
        {i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write, pmem_resp} = '0;
        i_pmem_address = '0; d_pmem_address = '0;
        i_pmem_wdata = '0; d_pmem_wdata = '0; pmem_rdata = '0;
        {f_i_pmem_read, f_i_pmem_write, f_d_pmem_read, f_d_pmem_write, f_pmem_resp} = '0;
        f_i_pmem_address = '0; f_d_pmem_address = '0;
        f_i_pmem_wdata = '0; f_d_pmem_wdata = '0; f_pmem_rdata = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_i_resp", i_pmem_resp, 0);

        // 1: async reset in the middle of a D transfer
        d_pmem_read = 1'b1; d_pmem_address = 32'h800;
        tick();
        chk("t1_serve_d", {pmem_read, pmem_address}, {1'b1, 32'h800});
        pmem_resp = 1'b1; pmem_rdata = A5;
        #1;
        chk("t1_d_resp_pre", d_pmem_resp, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_read", pmem_read, 0);
        chk("t1_rst_addr", pmem_address, 0);
        chk("t1_rst_d_resp", d_pmem_resp, 0);
        chk("t1_rst_d_rdata", d_pmem_rdata, 0);
        pmem_resp = 1'b0; d_pmem_read = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_idle", {pmem_read, pmem_write}, 0);

        // 3: both request after reset (last_grant=I): D first, then strict alternation
        d_pmem_write = 1'b1; d_pmem_address = 32'h800; d_pmem_wdata = WD;
        i_pmem_read = 1'b1; i_pmem_address = 32'h400;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                chk("t3_grant_d", {pmem_write, pmem_read, pmem_address}, {2'b10, 32'h800});
                chk("t3_wdata", pmem_wdata, WD);
            end else begin
                chk("t3_grant_i", {pmem_write, pmem_read, pmem_address}, {2'b01, 32'h400});
            end
            pmem_resp = 1'b1; pmem_rdata = mem_data(32'h100 + k);
            #1;
            chk("t3_resp", {i_pmem_resp, d_pmem_resp}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            pmem_resp = 1'b0;
            if (k == 7) begin
                d_pmem_write = 1'b0; i_pmem_read = 1'b0;
            end
            chk("t3_release", {pmem_read, pmem_write}, 0);
            tick();
            chk("t3_idle", {pmem_read, pmem_write}, 0);
        end

        // 2: I-only read, response routed to I in the same cycle
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0400;
        tick();
        chk("t2_read", {pmem_read, pmem_address}, {1'b1, 32'h400});
        chk("t2_no_early_resp", i_pmem_resp, 0);
        pmem_resp = 1'b1; pmem_rdata = A5;
        #1;
        chk("t2_i_resp", i_pmem_resp, 1);
        chk("t2_i_rdata", i_pmem_rdata, A5);
        chk("t2_d_resp", d_pmem_resp, 0);
        tick();
        pmem_resp = 1'b0; i_pmem_read = 1'b0;
        tick();

        // 5: I aborts before the response; a late response reaches nobody
        i_pmem_read = 1'b1; i_pmem_address = 32'h440;
        tick();
        chk("t5_serve_i", pmem_read, 1);
        i_pmem_read = 1'b0;
        tick();
        chk("t5_idle", pmem_read, 0);
        pmem_resp = 1'b1; pmem_rdata = A5;
        #1;
        chk("t5_no_resp", {i_pmem_resp, d_pmem_resp}, 0);
        chk("t5_no_rdata", i_pmem_rdata, 0);
        tick();
        chk("t5_still_idle", {pmem_read, i_pmem_resp}, 0);
        pmem_resp = 1'b0;
        tick();

        // Illegal read+write from I: forwarded unchanged and flagged
        i_pmem_read = 1'b1; i_pmem_write = 1'b1; i_pmem_address = 32'h480;
        tick();
        chk("ill_forward", {pmem_read, pmem_write}, 2'b11);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; i_pmem_read = 1'b0; i_pmem_write = 1'b0;
        tick();
        chk("ill_flagged", illegal_cnt != 0, 1);

        // 4: fixed priority, both requesting continuously -> D every time
        f_i_pmem_read = 1'b1; f_i_pmem_address = 32'h400;
        f_d_pmem_read = 1'b1; f_d_pmem_address = 32'h800;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_grant_d", {f_pmem_read, f_pmem_address}, {1'b1, 32'h800});
            f_pmem_resp = 1'b1;
            #1;
            chk("t4_resp", {f_i_pmem_resp, f_d_pmem_resp}, 2'b01);
            tick();
            f_pmem_resp = 1'b0;
            tick();
        end
        f_i_pmem_read = 1'b0; f_d_pmem_read = 1'b0;

        // 6: random requests with memory latency 1..20, then drain
        illegal_cnt = 0;
        {i_req, d_req, i_w, d_w, i_drop, d_drop, mem_busy} = '0;
        mem_lat = 0; i_wait = 0; d_wait = 0; max_wait = 0; n_req = 0; n_done = 0;
        for (int c = 0; c < 2400; c++) begin
            if (c >= 2000 && !i_req && !d_req) break;
            tick();
            if (i_drop) begin
                i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_req = 1'b0; i_drop = 1'b0;
            end else if (!i_req && c < 2000 && $urandom_range(0, 3) == 0) begin
                i_req = 1'b1; i_w = ($urandom_range(0, 7) == 0); i_wait = 0; n_req++;
                i_pmem_address = $urandom & 32'hFFFF_FFE0;
                i_pmem_wdata = {8{$urandom}};
                i_pmem_read = !i_w; i_pmem_write = i_w;
            end
            if (d_drop) begin
                d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_req = 1'b0; d_drop = 1'b0;
            end else if (!d_req && c < 2000 && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1; d_w = ($urandom_range(0, 1) == 0); d_wait = 0; n_req++;
                d_pmem_address = $urandom & 32'hFFFF_FFE0;
                d_pmem_wdata = {8{$urandom}};
                d_pmem_read = !d_w; d_pmem_write = d_w;
            end
            #1;
            pmem_resp = 1'b0;
            if (pmem_read || pmem_write) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1; mem_lat = $urandom_range(0, 19);
                end else begin
                    mem_lat--;
                end
                if (mem_lat == 0) begin
                    pmem_resp = 1'b1; pmem_rdata = mem_data(pmem_address); mem_busy = 1'b0;
                end
            end
            #1;
            if (pmem_resp) begin
                chk("rnd_one_resp", {1'b0, i_pmem_resp} + {1'b0, d_pmem_resp}, 1);
                if (i_pmem_resp) begin
                    chk("rnd_i_pending", {i_req, i_drop}, 2'b10);
                    chk("rnd_i_addr", pmem_address, i_pmem_address);
                    if (i_w) chk("rnd_i_wdata", {pmem_write, pmem_wdata}, {1'b1, i_pmem_wdata});
                    else     chk("rnd_i_rdata", i_pmem_rdata, mem_data(i_pmem_address));
                    i_drop = 1'b1; n_done++;
                end
                if (d_pmem_resp) begin
                    chk("rnd_d_pending", {d_req, d_drop}, 2'b10);
                    chk("rnd_d_addr", pmem_address, d_pmem_address);
                    if (d_w) chk("rnd_d_wdata", {pmem_write, pmem_wdata}, {1'b1, d_pmem_wdata});
                    else     chk("rnd_d_rdata", d_pmem_rdata, mem_data(d_pmem_address));
                    d_drop = 1'b1; n_done++;
                end
            end else begin
                chk("rnd_no_resp", {i_pmem_resp, d_pmem_resp}, 0);
            end
            if (i_req && !i_drop) i_wait++;
            if (d_req && !d_drop) d_wait++;
            if (i_wait > max_wait) max_wait = i_wait;
            if (d_wait > max_wait) max_wait = d_wait;
        end
        pmem_resp = 1'b0;
        chk("rnd_drained", {i_req, d_req}, 0);
        chk("rnd_all_served", n_done, n_req);
        chk("rnd_progress", n_done > 100, 1);
        chk("rnd_no_starve", max_wait <= 60, 1);
        chk("rnd_no_illegal", illegal_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
